dsi_wishbone_master: RTL

- Single-clock pipelined Wishbone master that drives the DSI core's 4-bit-address / 8-bit-data CSR bus from a simple command/response handshake.
- Used by the host-side init sequencer or the debug UART to read and write DSI core registers through the async bridge.
- Handles one outstanding transaction at a time and honours stall.
- A timeout counter aborts cycles that never see an ack.

---
 rtl/dsi_wishbone_master_if.sv | 37 +++
 rtl/dsi_wishbone_master.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dsi_wishbone_master_if.sv
// Command/response handshake and Wishbone CSR bus for the DSI Wishbone master.
// Signal suffixes are from the master's point of view.
interface dsi_wishbone_master_if;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic       cmd_we_i;
  logic [3:0] cmd_adr_i;
  logic [7:0] cmd_dat_i;

  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [7:0] rsp_dat_o;
  logic       rsp_err_o;

  logic [3:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic       wb_ack_i;
  logic       wb_stall_i;
  logic [7:0] wb_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i,
    input  wb_ack_i, wb_stall_i, wb_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i,
    output wb_ack_i, wb_stall_i, wb_dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o
  );
endinterface

// File: rtl/dsi_wishbone_master.sv
// Pipelined Wishbone master for the DSI CSR bus: one outstanding transaction,
// honours stall, aborts with an error response when no ack arrives in TIMEOUT cycles.
module dsi_wishbone_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 16
) (
  input  logic                   clk_wb_i,
  input  logic                   rst_n_i,
  dsi_wishbone_master_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StStrobe, StWaitAck, StResp} state_e;

  // Counter value on the edge at which it reaches TIMEOUT.
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            wb_cyc_q, wb_cyc_d;
  logic            wb_stb_q, wb_stb_d;
  logic            wb_we_q, wb_we_d;
  logic [3:0]      wb_adr_q, wb_adr_d;
  logic [7:0]      wb_dat_q, wb_dat_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;
  logic            to_hit;

  assign to_hit = (cnt_q == ToLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wb_cyc_d    = wb_cyc_q;
    wb_stb_d    = wb_stb_q;
    wb_we_d     = wb_we_q;
    wb_adr_d    = wb_adr_q;
    wb_dat_d    = wb_dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid_i) begin
          wb_we_d  = bus.cmd_we_i;
          wb_adr_d = bus.cmd_adr_i;
          wb_dat_d = bus.cmd_dat_i;
          wb_cyc_d = 1'b1;
          wb_stb_d = 1'b1;
          cnt_d    = '0;
          state_d  = StStrobe;
        end
      end

      StStrobe, StWaitAck: begin
        cnt_d = cnt_q + 1'b1;
        // An ack only counts once the request has been taken (no stall);
        // ack beats a timeout landing on the same edge.
        if (bus.wb_ack_i && (state_q == StWaitAck || !bus.wb_stall_i)) begin
          rsp_dat_d   = wb_we_q ? 8'h00 : bus.wb_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          wb_cyc_d    = 1'b0;
          wb_stb_d    = 1'b0;
          state_d     = StResp;
        end else if (to_hit) begin
          rsp_dat_d   = 8'h00;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          wb_cyc_d    = 1'b0;
          wb_stb_d    = 1'b0;
          state_d     = StResp;
        end else if (state_q == StStrobe && !bus.wb_stall_i) begin
          wb_stb_d = 1'b0;
          state_d  = StWaitAck;
        end
      end

      StResp: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_wb_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_adr_q    <= 4'h0;
      wb_dat_q    <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_stb_q    <= wb_stb_d;
      wb_we_q     <= wb_we_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready_o = (state_q == StIdle);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_dat_o   = rsp_dat_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.wb_cyc_o    = wb_cyc_q;
  assign bus.wb_stb_o    = wb_stb_q;
  assign bus.wb_we_o     = wb_we_q;
  assign bus.wb_adr_o    = wb_adr_q;
  assign bus.wb_dat_o    = wb_dat_q;

  a_stb_in_cyc : assert property (@(posedge clk_wb_i) disable iff (!rst_n_i)
    wb_stb_q |-> wb_cyc_q);

  a_rsp_no_cyc : assert property (@(posedge clk_wb_i) disable iff (!rst_n_i)
    rsp_valid_q |-> !wb_cyc_q);

  a_req_stable : assert property (@(posedge clk_wb_i) disable iff (!rst_n_i)
    (wb_stb_q && bus.wb_stall_i) |=>
      (wb_stb_q || !wb_cyc_q) && $stable(wb_adr_q) && $stable(wb_dat_q) && $stable(wb_we_q));

  a_rsp_stable : assert property (@(posedge clk_wb_i) disable iff (!rst_n_i)
    (rsp_valid_q && !bus.rsp_ready_i) |=>
      rsp_valid_q && $stable(rsp_dat_q) && $stable(rsp_err_q));

endmodule
